// File: rtl/force_release_responder.sv
// force_release_responder: target side of a per-bit force/release port.
// Ports: cmd_* handshake in, drv_in/bus_out data path, rsp_* and force_cnt status.
module force_release_responder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic [WIDTH-1:0] drv_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] forced_mask,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [CNT_W-1:0] force_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FORCE = 2'b01;
  localparam logic [1:0] OP_REL   = 2'b10;
  localparam logic [1:0] OP_RALL  = 2'b11;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] fmask_q, fmask_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    op_d        = op_q;
    mask_d      = mask_q;
    val_d       = val_q;
    fmask_d     = fmask_q;
    fval_d      = fval_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    // Uses the registered override, so new forces show one edge later.
    bus_d = (drv_in & ~fmask_q) | (fval_q & fmask_q);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          mask_d      = cmd_mask;
          val_d       = cmd_value;
          cmd_ready_d = 1'b0;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
        unique case (op_q)
          OP_FORCE: begin
            if (mask_q == '0) begin
              rsp_err_d = 1'b1;
            end else begin
              fmask_d = fmask_q | mask_q;
              fval_d  = (fval_q & ~mask_q) | (val_q & mask_q);
              if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
            end
          end
          OP_REL: begin
            // Forced bits in the mask are released even on error.
            rsp_err_d = (mask_q == '0) || ((mask_q & ~fmask_q) != '0);
            fmask_d   = fmask_q & ~mask_q;
            fval_d    = fval_q & ~mask_q;
          end
          OP_RALL: begin
            fmask_d = '0;
            fval_d  = '0;
          end
          OP_NOP: ;
          default: ;
        endcase
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      op_q        <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      fmask_q     <= '0;
      fval_q      <= '0;
      bus_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      val_q       <= val_d;
      fmask_q     <= fmask_d;
      fval_q      <= fval_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign bus_out     = bus_q;
  assign forced_mask = fmask_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign force_cnt   = cnt_q;

endmodule

// File: tb/tb_force_release_responder.sv
// Bench for force_release_responder: directed scenarios plus random commands
// checked against a bit-set model of the override state.
module tb_force_release_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_mask, cmd_value, drv_in;

  logic       cmd_ready, rsp_valid, rsp_err;
  logic [7:0] bus_out, forced_mask, force_cnt;
  logic       cmd_ready2, rsp_valid2, rsp_err2;
  logic [7:0] bus_out2, forced_mask2;
  logic [1:0] force_cnt2;

  int tests = 0;
  int fails = 0;

  // Model: which bits are forced, their values, count of valid FORCEs.
  logic [7:0] m_fm, m_fv;
  int         m_cnt;

  always #5 clk = ~clk;

  force_release_responder #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_value(cmd_value),
    .drv_in(drv_in), .bus_out(bus_out), .forced_mask(forced_mask),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .force_cnt(force_cnt)
  );

  force_release_responder #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_value(cmd_value),
    .drv_in(drv_in), .bus_out(bus_out2), .forced_mask(forced_mask2),
    .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .force_cnt(force_cnt2)
  );

  function automatic logic [7:0] exp_bus(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = m_fm[i] ? m_fv[i] : d[i];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_mask = 8'h00;
    cmd_value = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_fm = 8'h00;
    m_fv = 8'h00;
    m_cnt = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] m,
                          input logic [7:0] v);
    logic ee;
    int w;
    int c8, c2;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_mask = m;
    cmd_value = v;
    @(posedge clk);
    // Apply command to the model.
    ee = 1'b0;
    case (op)
      2'b01: begin
        if (m == 8'h00) ee = 1'b1;
        else begin
          for (int i = 0; i < 8; i++)
            if (m[i]) begin
              m_fm[i] = 1'b1;
              m_fv[i] = v[i];
            end
          m_cnt++;
        end
      end
      2'b10: begin
        if (m == 8'h00) ee = 1'b1;
        for (int i = 0; i < 8; i++)
          if (m[i]) begin
            if (!m_fm[i]) ee = 1'b1;
            m_fm[i] = 1'b0;
          end
      end
      2'b11: m_fm = 8'h00;
      default: ;
    endcase
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    // Keep valid high with junk: must be ignored while busy.
    #1;
    cmd_op = 2'($urandom);
    cmd_mask = 8'($urandom);
    cmd_value = 8'($urandom);
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy: got %b required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (forced_mask !== m_fm) begin
      fails++;
      $display("FAIL forced_mask: got %h required %h", forced_mask, m_fm);
    end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== ee) begin
      fails++;
      $display("FAIL rsp: valid=%b err=%b required 1/%b",
               rsp_valid, rsp_err, ee);
    end
    tests++;
    if (force_cnt !== 8'(c8) || force_cnt2 !== 2'(c2)) begin
      fails++;
      $display("FAIL force_cnt: got %0d/%0d required %0d/%0d",
               force_cnt, force_cnt2, c8, c2);
    end
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_apply: got %b required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rsp_end: valid=%b ready=%b required 0/1",
               rsp_valid, cmd_ready);
    end
    tests++;
    if (bus_out !== exp_bus(drv_in)) begin
      fails++;
      $display("FAIL bus_after_cmd: got %h required %h",
               bus_out, exp_bus(drv_in));
    end
  endtask

  task automatic drive_check(input logic [7:0] d);
    @(negedge clk);
    drv_in = d;
    @(posedge clk);
    #1;
    tests++;
    if (bus_out !== exp_bus(d)) begin
      fails++;
      $display("FAIL bus_follow: drv=%h got %h required %h",
               d, bus_out, exp_bus(d));
    end
  endtask

  task automatic test_reset();
    drv_in = 8'h00;
    do_reset();
    tests++;
    if (cmd_ready !== 1'b1 || forced_mask !== 8'h00 ||
        force_cnt !== 8'h00 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%b fm=%h cnt=%h rv=%b",
               cmd_ready, forced_mask, force_cnt, rsp_valid);
    end
    drive_check(8'hA5);
  endtask

  task automatic test_force();
    drv_in = 8'hF0;
    send_cmd(2'b01, 8'h0F, 8'h03);
    tests++;
    if (bus_out !== 8'hF3) begin
      fails++;
      $display("FAIL force_bus: got %h required f3", bus_out);
    end
  endtask

  task automatic test_hold_release();
    drive_check(8'h00);
    tests++;
    if (bus_out !== 8'h03) begin
      fails++;
      $display("FAIL hold_lo: got %h required 03", bus_out);
    end
    drive_check(8'hFF);
    tests++;
    if (bus_out !== 8'hF3) begin
      fails++;
      $display("FAIL hold_hi: got %h required f3", bus_out);
    end
    send_cmd(2'b10, 8'h03, 8'h00);
    tests++;
    if (forced_mask !== 8'h0C) begin
      fails++;
      $display("FAIL release_mask: got %h required 0c", forced_mask);
    end
    drive_check(8'h01);
    drive_check(8'h02);
  endtask

  task automatic test_errors();
    send_cmd(2'b10, 8'h30, 8'h00);
    send_cmd(2'b01, 8'h00, 8'hFF);
    send_cmd(2'b10, 8'h00, 8'h00);
    send_cmd(2'b00, 8'hFF, 8'hFF);
    send_cmd(2'b11, 8'h00, 8'h00);
    send_cmd(2'b11, 8'h00, 8'h00);
    send_cmd(2'b10, 8'h81, 8'h00);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++)
      send_cmd(2'b01, 8'(1 << i), 8'($urandom));
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_mask = 8'hFF;
    cmd_value = 8'h5A;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (forced_mask !== 8'h00 || bus_out !== 8'h00 ||
        rsp_valid !== 1'b0 || force_cnt !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: fm=%h bus=%h rv=%b cnt=%h",
               forced_mask, bus_out, rsp_valid, force_cnt);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_rsp: got %b required 0", rsp_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_fm = 8'h00;
    m_fv = 8'h00;
    m_cnt = 0;
    @(posedge clk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || forced_mask !== 8'h00 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: ready=%b fm=%h rv=%b",
               cmd_ready, forced_mask, rsp_valid);
    end
    drive_check(8'h3C);
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int n = 0; n < 60; n++) begin
      drv_in = 8'($urandom);
      op = 2'($urandom_range(0, 9) < 5 ? 1 : $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        send_cmd(op, 8'h00, 8'($urandom));
      else
        send_cmd(op, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0)
        drive_check(8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_force();
    test_hold_release();
    test_errors();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
